// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues reads to a one-cycle-latency instruction memory,
// buffers returned words with their fetch address, and hands them to the decoder.
module fetch_unit #(
    parameter int                       WIDTH         = 16,
    parameter int                       COUNTER_WIDTH = 8,
    parameter int                       DEPTH         = 4,
    parameter logic [COUNTER_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic [COUNTER_WIDTH-1:0] mem_addr,
    output logic                     mem_rd_en,
    input  logic [WIDTH-1:0]         mem_rdata,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [WIDTH-1:0]         instruction,
    output logic [COUNTER_WIDTH-1:0] instr_pc,
    input  logic                     jump_valid,
    input  logic [COUNTER_WIDTH-1:0] jump_target
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // Handshake: a word transfers to the decoder in any cycle where
    // instr_valid and instr_ready are both high at the rising edge.

    logic [COUNTER_WIDTH-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [PTR_W-1:0]         head_q, head_d;
    logic [PTR_W-1:0]         tail_q, tail_d;
    logic                     inflight_q, inflight_d;
    logic [COUNTER_WIDTH-1:0] inflight_pc_q, inflight_pc_d;

    logic [WIDTH-1:0]         word_q [DEPTH];
    logic [COUNTER_WIDTH-1:0] tag_q  [DEPTH];

    logic             not_empty;
    logic             issue;
    logic             push;
    logic             pop;
    logic [CNT_W:0]   occupancy;

    always_comb begin
        not_empty = (count_q != '0);
        occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
        // A same-cycle pop is deliberately not credited toward free space.
        issue     = reset & ~jump_valid & (occupancy < (CNT_W+1)'(DEPTH));
        // A return coinciding with a jump is wrong-path and is dropped.
        push      = reset & inflight_q & ~jump_valid;
        pop       = reset & not_empty & instr_ready;
    end

    always_comb begin
        pc_d          = pc_q;
        count_d       = count_q;
        head_d        = head_q;
        tail_d        = tail_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (jump_valid) begin
            pc_d    = jump_target;
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            if (issue) begin
                pc_d          = pc_q + 1'b1;
                inflight_pc_d = pc_q;
            end
            if (push) tail_d = tail_q + 1'b1;
            if (pop)  head_d = head_q + 1'b1;
            count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            count_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            count_q       <= count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            word_q[tail_q] <= mem_rdata;
            tag_q[tail_q]  <= inflight_pc_q;
        end
    end

    always_comb begin
        mem_rd_en   = issue;
        mem_addr    = reset ? pc_q : '0;
        instr_valid = reset & not_empty;
        instruction = instr_valid ? word_q[head_q] : '0;
        instr_pc    = instr_valid ? tag_q[head_q]  : '0;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model returns addr+0x100 one cycle after a read.
module tb_fetch_unit;
    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  mem_addr;
    logic        mem_rd_en;
    logic [15:0] mem_rdata = 16'hdead;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instruction;
    logic [7:0]  instr_pc;
    logic        jump_valid;
    logic [7:0]  jump_target;

    int tests_run = 0;
    int tests_failed = 0;

    fetch_unit #(
        .WIDTH(16), .COUNTER_WIDTH(8), .DEPTH(4), .RESET_PC(8'h00)
    ) dut (
        .clock(clock), .reset(reset),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .instr_pc(instr_pc),
        .jump_valid(jump_valid), .jump_target(jump_target)
    );

    always #5 clock = ~clock;

    // Synchronous instruction memory, mem[i] = i + 0x100.
    always @(posedge clock) begin
        if (mem_rd_en) mem_rdata <= 16'h0100 + {8'h00, mem_addr};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic expect_head(input string tag, input logic [15:0] ins, input logic [7:0] pc);
        check({tag, ".valid"}, {31'd0, instr_valid}, 32'd1);
        check({tag, ".instr"}, {16'd0, instruction}, {16'd0, ins});
        check({tag, ".pc"}, {24'd0, instr_pc}, {24'd0, pc});
    endtask

    task automatic expect_zero(input string tag);
        check({tag, ".rd_en"}, {31'd0, mem_rd_en}, 32'd0);
        check({tag, ".addr"}, {24'd0, mem_addr}, 32'd0);
        check({tag, ".valid"}, {31'd0, instr_valid}, 32'd0);
        check({tag, ".instr"}, {16'd0, instruction}, 32'd0);
        check({tag, ".pc"}, {24'd0, instr_pc}, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        instr_ready = 1'b0;
        jump_valid = 1'b0;
        jump_target = 8'h00;
        tick();
        tick();
        settle();
        expect_zero("reset");

        // Reset release, streaming with ready high.
        tick();
        reset = 1'b1;
        instr_ready = 1'b1;
        settle();
        check("s.c0.rd_en", {31'd0, mem_rd_en}, 32'd1);
        check("s.c0.addr", {24'd0, mem_addr}, 32'h00);
        check("s.c0.valid", {31'd0, instr_valid}, 32'd0);
        tick();
        settle();
        check("s.c1.valid", {31'd0, instr_valid}, 32'd0);
        check("s.c1.addr", {24'd0, mem_addr}, 32'h01);
        tick();
        settle();
        expect_head("s.c2", 16'h0100, 8'h00);
        for (int k = 1; k <= 5; k++) begin
            tick();
            settle();
            expect_head("s.stream", 16'h0100 + 16'(k), 8'(k));
        end

        // Back-pressure from reset: four issues, then stall with head held.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        instr_ready = 1'b0;
        settle();
        check("bp.c0.addr", {24'd0, mem_addr}, 32'h00);
        for (int c = 1; c <= 3; c++) begin
            tick();
            settle();
            check("bp.issue", {31'd0, mem_rd_en}, 32'd1);
        end
        for (int c = 4; c <= 6; c++) begin
            tick();
            settle();
            check("bp.stall", {31'd0, mem_rd_en}, 32'd0);
            check("bp.hold.instr", {16'd0, instruction}, 32'h0100);
            check("bp.hold.pc", {24'd0, instr_pc}, 32'h00);
        end
        tick();
        instr_ready = 1'b1;
        settle();
        expect_head("bp.c7", 16'h0100, 8'h00);
        check("bp.c7.rd_en", {31'd0, mem_rd_en}, 32'd0);
        tick();
        settle();
        expect_head("bp.c8", 16'h0101, 8'h01);
        check("bp.c8.rd_en", {31'd0, mem_rd_en}, 32'd1);
        check("bp.c8.addr", {24'd0, mem_addr}, 32'h04);
        for (int k = 2; k <= 4; k++) begin
            tick();
            settle();
            expect_head("bp.drain", 16'h0100 + 16'(k), 8'(k));
        end

        // Jump taken while popping pc 5; pcs 6.. must never appear.
        tick();
        jump_valid = 1'b1;
        jump_target = 8'h40;
        settle();
        expect_head("j.t", 16'h0105, 8'h05);
        check("j.t.rd_en", {31'd0, mem_rd_en}, 32'd0);
        tick();
        jump_valid = 1'b0;
        settle();
        check("j.t1.rd_en", {31'd0, mem_rd_en}, 32'd1);
        check("j.t1.addr", {24'd0, mem_addr}, 32'h40);
        check("j.t1.valid", {31'd0, instr_valid}, 32'd0);
        tick();
        settle();
        check("j.t2.valid", {31'd0, instr_valid}, 32'd0);
        tick();
        settle();
        expect_head("j.t3", 16'h0140, 8'h40);
        tick();
        instr_ready = 1'b0;
        settle();
        expect_head("j.t4", 16'h0141, 8'h41);

        // Jump against a full queue with ready low.
        for (int c = 0; c < 6; c++) tick();
        settle();
        check("full.rd_en", {31'd0, mem_rd_en}, 32'd0);
        expect_head("full.hold", 16'h0141, 8'h41);
        tick();
        jump_valid = 1'b1;
        jump_target = 8'h80;
        settle();
        check("fj.t.rd_en", {31'd0, mem_rd_en}, 32'd0);
        tick();
        jump_valid = 1'b0;
        settle();
        check("fj.t1.addr", {24'd0, mem_addr}, 32'h80);
        check("fj.t1.valid", {31'd0, instr_valid}, 32'd0);
        tick();
        settle();
        check("fj.t2.valid", {31'd0, instr_valid}, 32'd0);
        tick();
        settle();
        expect_head("fj.t3", 16'h0180, 8'h80);

        // Address wrap 0xFE -> 0x01.
        tick();
        instr_ready = 1'b1;
        jump_valid = 1'b1;
        jump_target = 8'hFE;
        tick();
        jump_valid = 1'b0;
        tick();
        tick();
        settle();
        expect_head("w.fe", 16'h01FE, 8'hFE);
        tick();
        settle();
        expect_head("w.ff", 16'h01FF, 8'hFF);
        tick();
        settle();
        expect_head("w.00", 16'h0100, 8'h00);
        tick();
        settle();
        expect_head("w.01", 16'h0101, 8'h01);

        // One-cycle reset mid-stream with a read in flight.
        tick();
        reset = 1'b0;
        settle();
        expect_zero("mr");
        tick();
        reset = 1'b1;
        settle();
        check("mr.c0.rd_en", {31'd0, mem_rd_en}, 32'd1);
        check("mr.c0.addr", {24'd0, mem_addr}, 32'h00);
        check("mr.c0.valid", {31'd0, instr_valid}, 32'd0);
        tick();
        settle();
        check("mr.c1.valid", {31'd0, instr_valid}, 32'd0);
        tick();
        settle();
        expect_head("mr.c2", 16'h0100, 8'h00);
        tick();
        settle();
        expect_head("mr.c3", 16'h0101, 8'h01);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
